// File: rtl/icache_pkg.sv
// icache_pkg: cache geometry, FSM states, bus types and address helpers
package icache_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED = 2'd0, AXI_BURST_INCR = 2'd1} axi_burst_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef enum logic [1:0] {IDLE, REFILL, UNCACHED} icache_state_t;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OFS = 3 + $clog2(WORDS);
  localparam int IDX = $clog2(LINES);
  localparam int TAG_W = 32 - OFS - IDX;
  localparam int WB = WORDS > 1 ? $clog2(WORDS) : 1;
  function automatic logic [IDX-1:0] index_of(input logic [31:0] a);
    return a[OFS+IDX-1:OFS];
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return a[31:OFS+IDX];
  endfunction
  function automatic logic [WB-1:0] word_of(input logic [31:0] a);
    return WB'((a >> 3) & 32'(WORDS - 1));
  endfunction
  function automatic mlen_t mlen_of(input int w);
    return mlen_t'(4'(w - 1));
  endfunction
endpackage

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch port, flush and cbus channel of the instruction cache
interface icache_direct_if;
  import icache_pkg::*;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       flush;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  modport master (output ireq, flush, cresp, input iresp, creq);
  modport slave (input ireq, flush, cresp, output iresp, creq);
endinterface

// File: rtl/icache_data_ram.sv
// icache_data_ram: line storage, one synchronous word write port and one combinational line read port
module icache_data_ram import icache_pkg::*; (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX-1:0]         widx,
  input  logic [WB-1:0]          wword,
  input  logic [63:0]            wdata,
  input  logic [IDX-1:0]         ridx,
  output logic [WORDS-1:0][63:0] rline
);
  logic [WORDS-1:0][63:0] mem [LINES];
  always_ff @(posedge clk)
    if (we) mem[widx][wword] <= wdata;
  assign rline = mem[ridx];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with burst refill and uncached bypass
module icache_direct import icache_pkg::*; (
  input logic            clk,
  input logic            reset,
  icache_direct_if.slave bus
);
  icache_state_t          state, state_nx;
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tags [LINES];
  logic [31:0]            addr_q;
  logic [WB-1:0]          beat;
  logic [WORDS-1:0][63:0] line;
  logic [63:0]            word;
  logic [IDX-1:0]         ridx, widx;
  logic                   hit, done, fill, ok;
  assign ridx = index_of(bus.ireq.addr);
  assign widx = index_of(addr_q);
  assign hit = bus.ireq.valid && bus.ireq.addr[31] && valid[ridx] && tags[ridx] == tag_of(bus.ireq.addr);
  assign done = bus.cresp.ready && bus.cresp.last;
  assign fill = state == REFILL && done;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state != IDLE ? (done ? IDLE : state) :
               (!bus.ireq.valid || hit) ? IDLE : bus.ireq.addr[31] ? REFILL : UNCACHED;
  // flush wins over a completing fill so a line refilled across a fence.i stays invalid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid  <= '0;
      addr_q <= '0;
      beat   <= '0;
    end else begin
      if (state == IDLE) begin
        addr_q <= bus.ireq.addr[31] ? {bus.ireq.addr[31:OFS], OFS'(0)} : bus.ireq.addr;
        beat   <= '0;
      end else if (bus.cresp.ready) beat <= beat + 1'b1;
      valid <= bus.flush ? '0 : fill ? valid | (LINES'(1) << widx) : valid;
    end
  always_ff @(posedge clk)
    if (fill) tags[widx] <= tag_of(addr_q);
  icache_data_ram u_ram (
    .clk  (clk),
    .we   (state == REFILL && bus.cresp.ready),
    .widx (widx),
    .wword(beat),
    .wdata(bus.cresp.data),
    .ridx (ridx),
    .rline(line)
  );
  always_comb begin
    word = line[word_of(bus.ireq.addr)];
    ok = (state == IDLE && hit) || (state == UNCACHED && done);
    bus.iresp = '0;
    bus.iresp.addr_ok = ok;
    bus.iresp.data_ok = ok;
    bus.iresp.data = !ok ? '0 :
                     state == UNCACHED ? (addr_q[2] ? bus.cresp.data[63:32] : bus.cresp.data[31:0]) :
                     bus.ireq.addr[2] ? word[63:32] : word[31:0];
    bus.creq = '0;
    bus.creq.valid = state != IDLE;
    bus.creq.addr = state != IDLE ? addr_q : '0;
    bus.creq.size = state == REFILL ? MSIZE8 : state == UNCACHED ? MSIZE4 : MSIZE1;
    bus.creq.len = state == REFILL ? mlen_of(WORDS) : MLEN1;
    bus.creq.burst = state == REFILL ? AXI_BURST_INCR : AXI_BURST_FIXED;
  end
endmodule
